// File: rtl/ahb_lite_test_master.sv
// Single-transfer AHB-Lite master with a command/response front end.
// Handles wait states, ERROR responses, wait-state timeout and alignment checks.
module ahb_lite_test_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   haddr_d;
  logic [2:0]      hsize_d;
  logic [1:0]      htrans_d;
  logic [DW-1:0]   hwdata_d;
  logic            hwrite_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d, wait_inc;
  logic            err_flag, err_flag_d;
  logic            rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic            rsp_err_d;
  logic            rsp_timeout_d;
  logic            misaligned;
  logic            timeout_hit;

  assign HBURST    = 3'b000;
  assign cmd_ready = (state == ST_IDLE);

  // Illegal sizes are rejected together with misaligned addresses
  assign misaligned = (cmd_size > 3'd2) ||
                      ((cmd_size == 3'd1) && cmd_addr[0]) ||
                      ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

  // Abort on the edge that would make the wait count reach the limit
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !HREADY &&
                       ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  assign wait_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    haddr_d       = HADDR;
    hsize_d       = HSIZE;
    htrans_d      = HTRANS;
    hwdata_d      = HWDATA;
    hwrite_d      = HWRITE;
    wdata_d       = wdata_q;
    wait_cnt_d    = wait_cnt;
    err_flag_d    = err_flag;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (misaligned) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end else begin
            haddr_d    = cmd_addr;
            hwrite_d   = cmd_write;
            hsize_d    = cmd_size;
            htrans_d   = TRANS_NONSEQ;
            wdata_d    = cmd_wdata;
            wait_cnt_d = '0;
            err_flag_d = 1'b0;
            state_d    = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          htrans_d   = TRANS_IDLE;
          wait_cnt_d = '0;
          state_d    = ST_DATA;
          if (HWRITE) hwdata_d = wdata_q;
        end else if (timeout_hit) begin
          htrans_d      = TRANS_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_err_d     = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      ST_DATA: begin
        if (HREADY) begin
          if (!HWRITE) rsp_rdata_d = HRDATA;
          rsp_err_d     = err_flag | HRESP;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_IDLE;
        end else if (timeout_hit) begin
          htrans_d      = TRANS_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_err_d     = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_inc;
          if (HRESP) err_flag_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      HADDR       <= '0;
      HSIZE       <= '0;
      HTRANS      <= TRANS_IDLE;
      HWDATA      <= '0;
      HWRITE      <= 1'b0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      err_flag    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      HADDR       <= haddr_d;
      HSIZE       <= hsize_d;
      HTRANS      <= htrans_d;
      HWDATA      <= hwdata_d;
      HWRITE      <= hwrite_d;
      wdata_q     <= wdata_d;
      wait_cnt    <= wait_cnt_d;
      err_flag    <= err_flag_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_test_master.sv
// Directed bench for ahb_lite_test_master with a scripted single-register slave.
module tb_ahb_lite_test_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;

  int checks = 0;
  int errors = 0;
  logic [31:0] slave_word = 32'h0;

  always #5 HCLK = ~HCLK;

  ahb_lite_test_master #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command and script the slave: aw address-phase waits, dw data-phase
  // waits, optional two-cycle ERROR ending the data phase.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input int aw, input int dw, input logic err, input logic bus,
                         input int exp_lat, input logic exp_err, input logic exp_to,
                         input logic [31:0] exp_rdata);
    int  k;
    int  j;
    bit  got;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    @(negedge HCLK);
    k = 1; got = 1'b0;
    while (k <= 40 && !got) begin
      if (rsp_valid) begin
        got = 1'b1;
        cmd_valid = 1'b0;
      end else begin
        // Busy-time command must be ignored
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFF0;
        cmd_size = 3'd2; cmd_wdata = 32'hBAD0_BAD0;
        if (!bus) begin
          check({tag, " no bus"}, 32'(HTRANS), 32'd0);
        end else if (k <= aw + 1) begin
          HREADY = (k == aw + 1);
          HRESP  = 1'b0;
          check({tag, " nonseq"}, 32'(HTRANS), 32'd2);
          check({tag, " haddr"}, HADDR, addr);
          check({tag, " hsize"}, 32'(HSIZE), 32'(size));
          check({tag, " hwrite"}, 32'(HWRITE), 32'(wr));
        end else begin
          j = k - aw - 2;
          HREADY = (j >= dw);
          HRESP  = err && (j >= dw - 1);
          HRDATA = slave_word;
          check({tag, " data idle"}, 32'(HTRANS), 32'd0);
          if (wr && j == dw) begin
            check({tag, " hwdata"}, HWDATA, wdata);
            slave_word = HWDATA;
          end
        end
        @(negedge HCLK);
        k++;
      end
    end
    HREADY = 1'b1; HRESP = 1'b0;
    if (!got) begin
      check({tag, " rsp never came"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, 32'(k), 32'(exp_lat));
      check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
      check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
      check({tag, " htrans end"}, 32'(HTRANS), 32'd0);
      check({tag, " ready end"}, 32'(cmd_ready), 32'd1);
      @(negedge HCLK);
      check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_size = 3'd0; cmd_wdata = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(negedge HCLK);
    check("rst htrans", 32'(HTRANS), 32'd0);
    check("rst haddr", HADDR, 32'h0);
    check("rst hburst", 32'(HBURST), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    HRESET = 1'b0;

    //        tag        wr    addr          sz    wdata          aw   dw  err   bus  lat err  to   rdata
    run_cmd("wr0",     1'b1, 32'h10,       3'd2, 32'hDEADBEEF,  0,   0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    run_cmd("rd0",     1'b0, 32'h10,       3'd2, 32'h0,         0,   0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'hDEADBEEF);
    run_cmd("wr_wait", 1'b1, 32'h20,       3'd2, 32'h12345678,  2,   2, 1'b0, 1'b1, 7, 1'b0, 1'b0, 32'hDEADBEEF);
    run_cmd("rd_wait", 1'b0, 32'h20,       3'd2, 32'h0,         2,   2, 1'b0, 1'b1, 7, 1'b0, 1'b0, 32'h12345678);
    run_cmd("rd_err",  1'b0, 32'h24,       3'd2, 32'h0,         0,   1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 32'h12345678);
    run_cmd("rd_tmo",  1'b0, 32'h28,       3'd2, 32'h0,       100,   0, 1'b0, 1'b1, 5, 1'b0, 1'b1, 32'h12345678);
    run_cmd("mis_w",   1'b0, 32'h2,        3'd2, 32'h0,         0,   0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h12345678);
    run_cmd("mis_h",   1'b1, 32'h1,        3'd1, 32'h5555,      0,   0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h12345678);
    run_cmd("bad_sz",  1'b0, 32'h0,        3'd3, 32'h0,         0,   0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h12345678);
    run_cmd("wr_half", 1'b1, 32'h2,        3'd1, 32'h0000ABCD,  0,   0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h12345678);
    run_cmd("rd_byte", 1'b0, 32'h3,        3'd0, 32'h0,         1,   0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 32'h0000ABCD);

    // Reset asserted in the data phase of a write
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_size = 3'd2;
    cmd_wdata = 32'hCAFEF00D; HREADY = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("mid nonseq", 32'(HTRANS), 32'd2);
    @(negedge HCLK);
    check("mid hwdata", HWDATA, 32'hCAFEF00D);
    HREADY = 1'b0;
    #1 HRESET = 1'b1;
    #1;
    check("mid rst hwdata", HWDATA, 32'h0);
    check("mid rst haddr", HADDR, 32'h0);
    check("mid rst hwrite", 32'(HWRITE), 32'd0);
    check("mid rst cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge HCLK);
    HRESET = 1'b0; HREADY = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      check("mid no rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd("post_rst", 1'b0, 32'h40, 3'd2, 32'h0, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h0000ABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
